// File: rtl/ysyx_22040632_dflush_unit.sv
// ysyx_22040632_dflush_unit: dcache flush engine writing each dirty line back as an 8-beat burst.
// Define YSYX_22040632_DFLUSH_RETRY_EN to re-issue a failed burst up to MAX_RETRY times.
module ysyx_22040632_dflush_unit #(
  parameter int TAG_W     = 21,
  parameter int IDX_W     = 5,
  parameter int DATA_W    = 64,
  parameter int BEATS     = 8,
  parameter int MAX_RETRY = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_req,
  output logic              busy,
  output logic              flush_done,
  output logic              flush_err,
  input  logic [31:0]       dirty_array_1st,
  input  logic [31:0]       dirty_array_2nd,
  output logic              tag_rd_way,
  output logic [IDX_W-1:0]  tag_rd_index,
  input  logic [TAG_W-1:0]  tag_read,
  output logic              flush_tag_f,
  output logic              data_rd_en,
  output logic              data_rd_way,
  output logic [IDX_W-1:0]  data_rd_index,
  output logic [2:0]        data_rd_beat,
  input  logic [DATA_W-1:0] data_rd_data,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [31:0]       aw_addr,
  output logic [7:0]        aw_len,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic              w_last,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [1:0]        b_resp
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SCAN   = 3'd1;
  localparam logic [2:0] ADDR   = 3'd2;
  localparam logic [2:0] WSEND  = 3'd3;
  localparam logic [2:0] WFETCH = 3'd4;
  localparam logic [2:0] RESP   = 3'd5;
  localparam logic [2:0] CLEAR  = 3'd6;
  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);
  logic [2:0]        state;
  logic [63:0]       pending;
  logic [BW-1:0]     beat;
  logic              cur_way;
  logic [IDX_W-1:0]  cur_idx;
  logic [TAG_W-1:0]  cur_tag;
  logic [DATA_W-1:0] wbuf;
  logic              first;
  logic              found;
  logic              sel_way;
  logic [IDX_W-1:0]  sel_idx;
  logic              line_done;
`ifdef YSYX_22040632_DFLUSH_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 1);
  logic [RW-1:0]     retry;
  assign line_done = (b_resp == 2'd0) || (retry == RW'(MAX_RETRY));
`else
  assign line_done = 1'b1;
`endif
  // Lines are ordered set-major, way 0 before way 1; scanning downward leaves the lowest one selected.
  always_comb begin
    found   = 1'b0;
    sel_way = 1'b0;
    sel_idx = '0;
    for (int n = 63; n >= 0; n--)
      if (pending[(n % 2) * 32 + n / 2]) begin
        found   = 1'b1;
        sel_way = 1'(n % 2);
        sel_idx = IDX_W'(n / 2);
      end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= '0;
      beat      <= '0;
      flush_err <= 1'b0;
      cur_way   <= 1'b0;
      cur_idx   <= '0;
      cur_tag   <= '0;
      wbuf      <= '0;
      first     <= 1'b0;
`ifdef YSYX_22040632_DFLUSH_RETRY_EN
      retry     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (flush_req) begin
          pending   <= {dirty_array_2nd, dirty_array_1st};
          flush_err <= 1'b0;
          state     <= SCAN;
        end
        SCAN: if (found) begin
          cur_way <= sel_way;
          cur_idx <= sel_idx;
          cur_tag <= tag_read;
          beat    <= '0;
          first   <= 1'b1;
          state   <= ADDR;
        end else
          state <= CLEAR;
        ADDR: begin
          if (first) wbuf <= data_rd_data;
          first <= 1'b0;
          if (aw_ready) state <= WSEND;
        end
        WSEND: if (w_ready) state <= (beat == LAST) ? RESP : WFETCH;
        WFETCH: begin
          wbuf  <= data_rd_data;
          beat  <= beat + 1'b1;
          state <= WSEND;
        end
        RESP: if (b_valid) begin
          if (line_done) pending[(cur_way ? 32 : 0) + int'(cur_idx)] <= 1'b0;
          if (line_done && b_resp != 2'd0) flush_err <= 1'b1;
`ifdef YSYX_22040632_DFLUSH_RETRY_EN
          retry <= line_done ? '0 : retry + 1'b1;
`endif
          state <= SCAN;
        end
        CLEAR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign busy          = state != IDLE;
  assign flush_done    = state == CLEAR;
  assign flush_tag_f   = state == CLEAR;
  assign tag_rd_way    = (state == SCAN) && sel_way;
  assign tag_rd_index  = (state == SCAN) ? sel_idx : '0;
  assign data_rd_en    = ((state == SCAN) && found) || ((state == WSEND) && w_ready && beat != LAST);
  assign data_rd_way   = (state == SCAN) ? sel_way : cur_way;
  assign data_rd_index = (state == SCAN) ? sel_idx : cur_idx;
  assign data_rd_beat  = (state == WSEND) ? 3'(beat + 1'b1) : 3'd0;
  assign aw_valid      = state == ADDR;
  assign aw_addr       = 32'({cur_tag, cur_idx, 6'b0});
  assign aw_len        = 8'(BEATS - 1);
  assign w_valid       = state == WSEND;
  assign w_data        = wbuf;
  assign w_last        = (state == WSEND) && beat == LAST;
  assign b_ready       = state == RESP;
endmodule

// File: tb/tb_ysyx_22040632_dflush_unit.sv
// tb_ysyx_22040632_dflush_unit: table-driven and random flush scenarios against a line-order memory model.
module tb_ysyx_22040632_dflush_unit;
`ifdef YSYX_22040632_DFLUSH_RETRY_EN
  localparam int ERR_BURSTS = 4;
`else
  localparam int ERR_BURSTS = 1;
`endif
  logic clk = 0, rst = 1, flush_req = 0;
  logic busy, flush_done, flush_err, tag_rd_way, flush_tag_f, data_rd_en, data_rd_way;
  logic [31:0] dirty_array_1st = 0, dirty_array_2nd = 0, aw_addr;
  logic [4:0] tag_rd_index, data_rd_index;
  logic [20:0] tag_read;
  logic [2:0] data_rd_beat;
  logic [63:0] data_rd_data = 0, w_data;
  logic aw_valid, aw_ready = 0, w_valid, w_ready = 0, w_last, b_valid = 0, b_ready;
  logic [7:0] aw_len;
  logic [1:0] b_resp = 0;
  typedef struct { logic [31:0] d0, d1; bit bp, err, exp_err; } vec_t;
  vec_t vecs[10];
  logic [5:0] exp_q[$];
  logic [5:0] cur_line = 0, err_line = 0;
  int n_chk = 0, n_fail = 0, cyc = 0, wb = 0, shown_beat = 0;
  int done_cnt = 0, tag_f_cnt = 0, done_cyc = 0;
  bit bp = 0, err_mode = 0, aw_pend = 0, w_pend = 0;
  logic [31:0] aw_prev;
  logic [63:0] w_prev;

  ysyx_22040632_dflush_unit dut (
    .clk(clk), .rst(rst), .flush_req(flush_req), .busy(busy), .flush_done(flush_done),
    .flush_err(flush_err), .dirty_array_1st(dirty_array_1st), .dirty_array_2nd(dirty_array_2nd),
    .tag_rd_way(tag_rd_way), .tag_rd_index(tag_rd_index), .tag_read(tag_read),
    .flush_tag_f(flush_tag_f), .data_rd_en(data_rd_en), .data_rd_way(data_rd_way),
    .data_rd_index(data_rd_index), .data_rd_beat(data_rd_beat), .data_rd_data(data_rd_data),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_word(logic w, logic [4:0] i, logic [2:0] b);
    return {24'hC0FFEE, b, i, w, 31'h5A5A1234};
  endfunction
  function automatic logic [20:0] tag_of(logic w, logic [4:0] i);
    return (w && i == 5'd3) ? 21'h1ABCD : {i, w, 15'h2B3C};
  endfunction

  assign tag_read = tag_of(tag_rd_way, tag_rd_index);
  always @(posedge clk) if (data_rd_en) data_rd_data <= mem_word(data_rd_way, data_rd_index, data_rd_beat);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    aw_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    w_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    b_valid  = bp ? ($urandom_range(0, 2) == 0) : 1'b1;
    b_resp   = (err_mode && cur_line == err_line) ? 2'd2 : 2'd0;
  end

  always @(negedge clk) begin
    if (rst) begin
      aw_pend = 0;
      w_pend = 0;
    end else begin
      shown_beat = wb;
      if (aw_pend) begin
        chk("aw_hold_valid", 64'(aw_valid), 1);
        chk("aw_hold_addr", 64'(aw_addr), 64'(aw_prev));
      end
      if (w_pend) begin
        chk("w_hold_valid", 64'(w_valid), 1);
        chk("w_hold_data", w_data, w_prev);
      end
      aw_pend = aw_valid && !aw_ready;
      aw_prev = aw_addr;
      w_pend = w_valid && !w_ready;
      w_prev = w_data;
      if (aw_valid && aw_ready) begin
        chk("aw_expected", 64'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          cur_line = exp_q.pop_front();
          chk("aw_addr", 64'(aw_addr), 64'({tag_of(cur_line[5], cur_line[4:0]), cur_line[4:0], 6'b0}));
          chk("aw_len", 64'(aw_len), 7);
          wb = 0;
        end
      end
      if (w_valid && w_ready) begin
        chk("w_data", w_data, mem_word(cur_line[5], cur_line[4:0], 3'(wb)));
        chk("w_last", 64'(w_last), 64'(wb == 7));
        wb++;
      end
      if (flush_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("tag_f_with_done", 64'(flush_tag_f), 1);
      end
      if (flush_tag_f) tag_f_cnt++;
    end
  end

  task automatic start_flush(input vec_t v, output int c0, output int n);
    bit first = 1;
    bp = v.bp;
    err_mode = v.err;
    exp_q.delete();
    n = 0;
    for (int s = 0; s < 32; s++)
      for (int w = 0; w < 2; w++)
        if (w == 1 ? v.d1[s] : v.d0[s]) begin
          for (int r = 0; r < ((v.err && first) ? ERR_BURSTS : 1); r++) exp_q.push_back(6'({1'(w), 5'(s)}));
          if (first) err_line = 6'({1'(w), 5'(s)});
          first = 0;
          n++;
        end
    dirty_array_1st = v.d0;
    dirty_array_2nd = v.d1;
    @(posedge clk);
    #1 flush_req = 1;
    c0 = cyc;
    @(posedge clk);
    #1 flush_req = 0;
    dirty_array_1st = $urandom;
    dirty_array_2nd = $urandom;
  endtask

  task automatic run_flush(input vec_t v);
    int c0, n, d0, tf0;
    d0 = done_cnt;
    tf0 = tag_f_cnt;
    start_flush(v, c0, n);
    for (int k = 0; k < 20000 && done_cnt == d0; k++) begin
      @(negedge clk);
      #1;
    end
    chk("done_seen", 64'(done_cnt - d0), 1);
    if (!v.bp) chk("done_latency", 64'(done_cyc - c0), 64'(2 + 18 * n));
    chk("all_bursts_issued", 64'(exp_q.size()), 0);
    if (n > 0) chk("beats_last_burst", 64'(wb), 8);
    chk("flush_err", 64'(flush_err), 64'(v.exp_err));
    @(negedge clk);
    #1;
    chk("idle_after", 64'(busy), 0);
    chk("done_single_pulse", 64'(flush_done), 0);
    chk("tag_f_count", 64'(tag_f_cnt - tf0), 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, n, tf0;
    bit hit;
    vecs[0] = '{32'h0, 32'h0, 0, 0, 0};
    vecs[1] = '{32'h0, 32'h8, 0, 0, 0};
    vecs[2] = '{32'h8000_0001, 32'h1, 0, 0, 0};
    vecs[3] = '{32'h0, 32'h8, 0, 1, 1};
    vecs[4] = '{32'h0000_0100, 32'h0100_0010, 1, 1, 1};
    for (int i = 5; i < 10; i++) vecs[i] = '{$urandom & $urandom & $urandom, $urandom & $urandom & $urandom, 1, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(flush_done), 0);
    chk("rst_tag_f", 64'(flush_tag_f), 0);
    chk("rst_aw_valid", 64'(aw_valid), 0);
    chk("rst_w_valid", 64'(w_valid), 0);
    chk("rst_b_ready", 64'(b_ready), 0);
    chk("rst_data_rd_en", 64'(data_rd_en), 0);
    chk("rst_err", 64'(flush_err), 0);
    chk("rst_aw_addr", 64'(aw_addr), 0);
    chk("rst_w_data", w_data, 0);
    chk("rst_selects", 64'({tag_rd_index, data_rd_index, data_rd_beat}), 0);
    #1 rst = 0;
    foreach (vecs[i]) run_flush(vecs[i]);
    tf0 = tag_f_cnt;
    start_flush('{32'h0000_0030, 32'h0, 0, 0, 0}, c0, n);
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(negedge clk);
      #1;
      hit = w_valid && shown_beat == 4;
    end
    chk("reached_beat4", 64'(hit), 1);
    rst = 1;
    @(negedge clk);
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_w_valid", 64'(w_valid), 0);
    chk("abort_aw_valid", 64'(aw_valid), 0);
    chk("abort_rd_en", 64'(data_rd_en), 0);
    rst = 0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("abort_no_tag_f", 64'(tag_f_cnt - tf0), 0);
    run_flush('{32'h0, 32'h0000_0200, 0, 0, 0});
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
